dexie_store_gate: RTL
=====================

// Module: dexie_store_gate
// PURPOSE
// Sits downstream of the core's dexie_interface master port. Holds every LSU store at
// the stallOnStore point and forwards its pc/addr/len/data to an external policy checker
// over a valid/ready request channel. Releases the store via df_mem_continueStore on
// approval; on denial or timeout, latches a sticky violation and never releases it.
// PARAMETERS
// RESP_TIMEOUT  256  cycles allowed in WAIT_RESP before fault; 0 disables the timeout
// CNT_W         32   width of the approved-store counter (wraps at 2^CNT_W)
// PORTS
// clk                   in   1   core clock
// rst_n                 in   1   asynchronous active-low reset
// enable                in   1   gate enable; sampled only in IDLE
// df_mem_pc             in   32  PC of current LSU op
// df_mem_store          in   1   store pending in LSU
// df_mem_addr           in   32  store address
// df_mem_len            in   2   store length (funct3[1:0])
// df_mem_storedata      in   32  store data
// df_mem_stalling       in   1   LSU op stalled by DExIE
// df_mem_stallOnStore   out  1   to core: hold new stores
// df_mem_continueStore  out  1   to core: let held store proceed
// req_valid             out  1   checker request valid
// req_ready             in   1   checker accepts request
// req_pc/req_addr       out  32  captured store PC / address
// req_len               out  2   captured length
// req_data              out  32  captured store data
// resp_valid            in   1   checker verdict valid (single-cycle strobe)
// resp_ok               in   1   1=approve, 0=deny; valid with resp_valid
// violation             out  1   sticky: denied or timed-out store
// approved_cnt          out  CNT_W  number of stores released
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE; all outputs 0; captured regs, timer, counter 0.
// - df_mem_stallOnStore = enable_q & ~(state==PASS); enable_q is enable registered in IDLE.
// - IDLE: if enable_q=0 -> PASS-through (stallOnStore=0, no checks). Else, on
//   df_mem_store & df_mem_stalling: capture pc/addr/len/data into req_* regs -> REQ.
// - REQ: req_valid=1, req_* stable until req_valid&req_ready; then -> WAIT_RESP, timer=0.
//   Never retract req_valid once raised. resp_valid in REQ is ignored.
// - WAIT_RESP: timer++ each cycle. resp_valid&resp_ok -> RELEASE. resp_valid&~resp_ok ->
//   FAULT. RESP_TIMEOUT!=0 and timer==RESP_TIMEOUT-1 without resp_valid -> FAULT.
//   resp_valid in the same cycle as the timeout wins (verdict used).
// - RELEASE: df_mem_continueStore=1 until df_mem_stalling==0 is sampled; in that cycle
//   approved_cnt++ (wrap) and -> IDLE. Next store checked from IDLE one cycle later
//   (min 1 idle cycle between back-to-back stores; core stays stalled meanwhile).
// - PASS: entered from IDLE when enable_q=0; returns to IDLE when enable=1 sampled and
//   df_mem_store=0 (never enable gating in the middle of a store's issue).
// - FAULT: violation=1, stallOnStore=1, continueStore=0, req_valid=0; terminal until rst_n.
// - enable changes outside IDLE/PASS have no effect on the in-flight store.
// - Latency, enabled, ready/resp immediate: store seen cycle 0 -> req_valid cycle 1 ->
//   continueStore cycle 3 earliest.
// - rst_n mid-operation: immediate return to reset state; an in-flight checker request
//   is abandoned (checker must also be reset).
// - Loads are never gated; df_mem_load is not an input.
// TESTING
// 1 enable=1, store pc=0x100 addr=0x8000_0010 data=0xDEADBEEF len=2, ready&ok immediate
//   -> req_* match, continueStore high cycle 3 until stalling=0, approved_cnt=1.
// 2 req_ready held 0 for 5 cycles -> req_valid and req_* stable all 5 cycles, no release.
// 3 resp_ok=0 -> violation=1 next cycle, continueStore never asserts, later stores ignored.
// 4 RESP_TIMEOUT=4, no resp -> FAULT entered exactly 4 cycles after handshake; resp at
//   the 4th cycle with ok=1 instead -> RELEASE.
// 5 enable=0 -> stallOnStore=0, 10 stores pass, approved_cnt=0; raise enable mid-store ->
//   gating starts only after df_mem_store drops.
// 6 rst_n low during WAIT_RESP -> all outputs 0 asynchronously; CNT_W=2 with 5 approvals
//   -> approved_cnt=1 (wrap).

Source files
------------

// File: rtl/dexie_store_gate.sv
// Store gate between the DExIE master port and an external policy checker.
// Each store is held, sent to the checker, and released only on approval; denial or timeout is terminal.
module dexie_store_gate #(
  parameter int RESP_TIMEOUT = 256,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [31:0]      df_mem_pc,
  input  logic             df_mem_store,
  input  logic [31:0]      df_mem_addr,
  input  logic [1:0]       df_mem_len,
  input  logic [31:0]      df_mem_storedata,
  input  logic             df_mem_stalling,
  output logic             df_mem_stallOnStore,
  output logic             df_mem_continueStore,
  output logic             req_valid,
  input  logic             req_ready,
  output logic [31:0]      req_pc,
  output logic [31:0]      req_addr,
  output logic [1:0]       req_len,
  output logic [31:0]      req_data,
  input  logic             resp_valid,
  input  logic             resp_ok,
  output logic             violation,
  output logic [CNT_W-1:0] approved_cnt
);

  localparam int TW = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = (RESP_TIMEOUT == 0) ? TW'(0) : TW'(RESP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PASS      = 3'd1,
    REQ       = 3'd2,
    WAIT_RESP = 3'd3,
    RELEASE   = 3'd4,
    FAULT     = 3'd5
  } state_t;

  state_t           state_r, state_s;
  logic             enable_q_r, enable_q_s;
  logic [TW-1:0]    timer_r, timer_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             capture_s;

  // Next-state logic; enable_q only follows enable while no store is in flight.
  always_comb begin
    state_s    = state_r;
    enable_q_s = enable_q_r;
    timer_s    = timer_r;
    cnt_s      = cnt_r;
    capture_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (!enable_q_r) begin
          state_s = PASS;
        end else if (df_mem_store && df_mem_stalling) begin
          capture_s = 1'b1;
          state_s   = REQ;
        end else begin
          enable_q_s = enable;
        end
      end
      PASS: begin
        // Gating resumes only between stores, never mid-issue.
        if (enable && !df_mem_store) begin
          state_s    = IDLE;
          enable_q_s = 1'b1;
        end else begin
          state_s = PASS;
        end
      end
      REQ: begin
        if (req_ready) begin
          state_s = WAIT_RESP;
          timer_s = TW'(0);
        end else begin
          state_s = REQ;
        end
      end
      WAIT_RESP: begin
        timer_s = timer_r + TW'(1);
        if (resp_valid) begin
          state_s = resp_ok ? RELEASE : FAULT;
        end else if ((RESP_TIMEOUT != 0) && (timer_r == TMAX)) begin
          state_s = FAULT;
        end else begin
          state_s = WAIT_RESP;
        end
      end
      RELEASE: begin
        if (!df_mem_stalling) begin
          cnt_s   = cnt_r + CNT_W'(1);
          state_s = IDLE;
        end else begin
          state_s = RELEASE;
        end
      end
      FAULT: begin
        state_s = FAULT;
      end
      default: begin
        state_s = FAULT;
      end
    endcase
  end

  // State, timer and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      enable_q_r <= 1'b0;
      timer_r    <= TW'(0);
      cnt_r      <= CNT_W'(0);
    end else begin
      state_r    <= state_s;
      enable_q_r <= enable_q_s;
      timer_r    <= timer_s;
      cnt_r      <= cnt_s;
    end
  end

  // Outputs are registered from the next-state decode so they align with the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      df_mem_stallOnStore  <= 1'b0;
      df_mem_continueStore <= 1'b0;
      req_valid            <= 1'b0;
      violation            <= 1'b0;
    end else begin
      df_mem_stallOnStore  <= enable_q_s & (state_s != PASS);
      df_mem_continueStore <= (state_s == RELEASE);
      req_valid            <= (state_s == REQ);
      violation            <= (state_s == FAULT);
    end
  end

  // Captured store payload, held stable for the whole request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pc   <= 32'd0;
      req_addr <= 32'd0;
      req_len  <= 2'd0;
      req_data <= 32'd0;
    end else if (capture_s) begin
      req_pc   <= df_mem_pc;
      req_addr <= df_mem_addr;
      req_len  <= df_mem_len;
      req_data <= df_mem_storedata;
    end else begin
      req_pc   <= req_pc;
      req_addr <= req_addr;
      req_len  <= req_len;
      req_data <= req_data;
    end
  end

  assign approved_cnt = cnt_r;

endmodule
